jtag_user_reg_bank: RTL and testbench
=====================================

# jtag_user_reg_bank

Multi-channel JTAG user data register for the DCFEB/ODMB BSCAN user chain. It holds NREG independent WIDTH-bit channels behind a single BSCAN USER instruction, selected by ADDR. Each DR scan captures either external status (PI) or the channel's own output (readback), shifts LSB-first, and applies an UPDATE only when exactly WIDTH bits were shifted. Applied updates drive the parallel outputs PO and a one-cycle strobe.

## Interface
Parameters:
- WIDTH, 16, bits per channel (≥2)
- NREG, 4, number of channels (≥1)
- AW, 2, ADDR width; 2^AW ≥ NREG
- CAP_MASK, {NREG{1'b0}}, per-channel capture source: bit i = 1 captures PO[i] (readback), 0 captures PI[i]
- RST_VAL, {WIDTH{1'b0}}, reset value loaded into every PO channel

Ports:
- DRCK  in  1  scan clock; integration drives ungated TCK through Capture/Shift/Update-DR
- RST  in  1  reset; asynchronous, active-high
- SEL  in  1  BSCAN SEL for this USER instruction
- ADDR  in  AW  channel select; must be stable from CAPTURE through UPDATE
- TDI  in  1  serial data in
- CAPTURE  in  1  Capture-DR state
- SHIFT  in  1  Shift-DR state
- UPDATE  in  1  Update-DR state, one DRCK cycle
- CLR_ERR  in  1  clears LEN_ERR
- PI  in  NREG*WIDTH  capture data; channel i at [i*WIDTH +: WIDTH]
- PO  out  NREG*WIDTH  updated register contents, same packing
- UPD_STB  out  NREG  one-cycle pulse per channel on an applied update
- LEN_ERR  out  1  sticky flag: UPDATE seen with bit count ≠ WIDTH
- TDO  out  1  serial data out

## Operation
- ce = SEL & (ADDR < NREG). When ce = 0, all state holds except UPD_STB (returns to 0) and CLR_ERR handling. TDO = 0.
- Internal state:
  - shift register sr[WIDTH-1:0]
  - bit counter cnt, width clog2(WIDTH+2), saturating at WIDTH+1
  - PO, UPD_STB, LEN_ERR
- Priority on each DRCK rising edge with ce = 1: CAPTURE > SHIFT > UPDATE. Lower-priority inputs asserted in the same cycle are ignored.
- Capture:
  - sr <= CAP_MASK[ADDR] ? PO[ADDR] : PI[ADDR]
  - cnt <= 0
- Shift:
  - sr <= {TDI, sr[WIDTH-1:1]}
  - cnt <= min(cnt+1, WIDTH+1)
- Update:
  - If cnt == WIDTH: PO[ADDR] <= sr and UPD_STB[ADDR] <= 1.
  - Otherwise PO holds, no strobe, and LEN_ERR <= 1.
  - In both cases cnt <= 0.
- UPD_STB defaults to 0 every cycle it is not set; it is never high for more than one cycle per update.
- LEN_ERR:
  - cleared by CLR_ERR on a DRCK edge
  - If CLR_ERR and an erroring UPDATE coincide, set wins.
- TDO = ce & sr[0], combinational. The first captured bit is presented in the first Shift-DR cycle.
- Other channels' PO are never modified by a scan addressed elsewhere.
- Reset (asynchronous, any time including mid-scan):
  - sr = 0, cnt = 0, every PO channel = RST_VAL, UPD_STB = 0, LEN_ERR = 0
  - TDO = 0 while reset is held, since sr = 0.
  - An UPDATE after reset without a fresh CAPTURE and WIDTH shifts sets LEN_ERR.

## Timing
- All registers update on DRCK rising edge; RST is asynchronous assert and synchronous-to-DRCK deassert at integration.
- Capture-to-first-TDO: sr is valid after the CAPTURE edge, so TDO is valid through the first SHIFT cycle.
- Each SHIFT edge advances TDO by one bit. A full scan is 1 CAPTURE + WIDTH SHIFT + 1 UPDATE cycles.
- PO and UPD_STB change on the UPDATE edge (latency 1 cycle). UPD_STB drops on the next edge.
- Readback capture of a channel on the cycle after its update returns the new PO value.

## Test plan
Test configuration: WIDTH = 8, NREG = 4, CAP_MASK = 4'b0100, RST_VAL = 8'h00.

1. Reset check: pulse RST → PO = 32'h0, UPD_STB = 0, LEN_ERR = 0, TDO = 0.
2. Write and status readout on channel 1:
   - Stimulus: ADDR = 1, PI[1] = 8'hA5, CAPTURE, then 8 SHIFT cycles with TDI = 1, then UPDATE.
   - TDO sequence: 1,0,1,0,0,1,0,1.
   - Result: PO[1] = 8'hFF, UPD_STB = 4'b0010 for exactly one cycle; other channels stay 8'h00.
3. Short and long scans on channel 0:
   - CAPTURE, 7 SHIFT, UPDATE → PO[0] unchanged, no strobe, LEN_ERR = 1.
   - Repeat with 9 shifts → same result.
   - CLR_ERR → LEN_ERR = 0.
4. Readback on channel 2:
   - Write 8'h3C to channel 2.
   - CAPTURE with PI[2] = 8'hFF, shift out → TDO reads 0,0,1,1,1,1,0,0 (the PO value, not PI).
5. Deselect: SEL = 0 during 8 SHIFT cycles and an UPDATE → TDO = 0, sr and PO unchanged, no strobe, no LEN_ERR.
6. Reset mid-scan: assert RST after 4 shifts of a channel 3 write → PO[3] = 8'h00. After release, an UPDATE without a new CAPTURE sets LEN_ERR = 1 and PO[3] stays 8'h00.

Source files
------------

// File: rtl/jtag_user_reg_bank.sv
// jtag_user_reg_bank: multi-channel BSCAN USER data register bank.
//
// Holds NREG independent WIDTH-bit channels behind one USER instruction,
// selected by ADDR. Each DR scan captures either external status (PI) or the
// channel's own output (readback, per CAP_MASK bit), shifts LSB-first, and
// applies the scanned word on Update-DR only when exactly WIDTH bits were
// shifted. A wrong-length scan leaves PO untouched and sets LEN_ERR.
//
// Ports:
//   DRCK     scan clock (ungated TCK through Capture/Shift/Update-DR)
//   RST      asynchronous active-high reset
//   SEL      BSCAN SEL for this USER instruction
//   ADDR     channel select, held stable from Capture through Update
//   TDI      serial data in
//   CAPTURE  Capture-DR state
//   SHIFT    Shift-DR state
//   UPDATE   Update-DR state (one DRCK cycle)
//   CLR_ERR  clears LEN_ERR on a DRCK edge
//   PI       capture data, channel i at [i*WIDTH +: WIDTH]
//   PO       applied register contents, same packing as PI
//   UPD_STB  one-cycle per-channel pulse on an applied update
//   LEN_ERR  sticky: Update-DR seen with bit count != WIDTH
//   TDO      serial data out, combinational from the shift register
module jtag_user_reg_bank #(
    parameter int               WIDTH    = 16,
    parameter int               NREG     = 4,
    parameter int               AW       = 2,
    parameter logic [NREG-1:0]  CAP_MASK = '0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                  DRCK,
    input  logic                  RST,
    input  logic                  SEL,
    input  logic [AW-1:0]         ADDR,
    input  logic                  TDI,
    input  logic                  CAPTURE,
    input  logic                  SHIFT,
    input  logic                  UPDATE,
    input  logic                  CLR_ERR,
    input  logic [NREG*WIDTH-1:0] PI,
    output logic [NREG*WIDTH-1:0] PO,
    output logic [NREG-1:0]       UPD_STB,
    output logic                  LEN_ERR,
    output logic                  TDO
);

    // Counter saturates at WIDTH+1 so any over-long scan stays distinguishable
    // from an exact-length one no matter how many extra shifts occur.
    localparam int             CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);
    localparam logic [AW:0]    NREG_X   = (AW + 1)'(NREG);

    logic [WIDTH-1:0]      sr_q, sr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NREG*WIDTH-1:0] po_q, po_d;
    logic [NREG-1:0]       stb_q, stb_d;
    logic                  err_q, err_d;

    logic [AW:0]           addr_x;
    logic                  ce;
    logic [NREG-1:0]       hit;
    logic [WIDTH-1:0]      cap_val;

    // Extra top bit keeps the range check meaningful even when 2^AW == NREG.
    assign addr_x = {1'b0, ADDR};
    assign ce     = SEL && (addr_x < NREG_X);

    always_comb begin
        hit     = '0;
        cap_val = '0;
        for (int i = 0; i < NREG; i++) begin
            hit[i] = ce && (addr_x == (AW + 1)'(i));
            if (hit[i])
                cap_val = CAP_MASK[i] ? po_q[i*WIDTH +: WIDTH] : PI[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        po_d  = po_q;
        stb_d = '0;
        // A coincident erroring update below overrides this clear.
        err_d = err_q & ~CLR_ERR;
        if (ce && CAPTURE) begin
            sr_d  = cap_val;
            cnt_d = '0;
        end else if (ce && SHIFT) begin
            sr_d  = {TDI, sr_q[WIDTH-1:1]};
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
        end else if (ce && UPDATE) begin
            cnt_d = '0;
            if (cnt_q == CNT_FULL) begin
                for (int i = 0; i < NREG; i++)
                    if (hit[i])
                        po_d[i*WIDTH +: WIDTH] = sr_q;
                stb_d = hit;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            sr_q  <= '0;
            cnt_q <= '0;
            po_q  <= {NREG{RST_VAL}};
            stb_q <= '0;
            err_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            po_q  <= po_d;
            stb_q <= stb_d;
            err_q <= err_d;
        end
    end

    assign PO      = po_q;
    assign UPD_STB = stb_q;
    assign LEN_ERR = err_q;
    assign TDO     = ce & sr_q[0];

endmodule

// File: tb/tb_jtag_user_reg_bank.sv
// tb_jtag_user_reg_bank: scoreboard bench for jtag_user_reg_bank.
module tb_jtag_user_reg_bank;
    localparam int W = 8;
    localparam int N = 4;
    localparam int A = 2;
    localparam logic [N-1:0] CMASK = 4'b0100;

    typedef struct {
        logic [N-1:0]   stb;
        logic [N*W-1:0] po;
    } stb_t;

    typedef struct {
        logic [N*W-1:0] po;
        logic           err;
    } st_t;

    logic           DRCK = 1'b0;
    logic           RST = 1'b1;
    logic           SEL = 1'b0;
    logic [A-1:0]   ADDR = '0;
    logic           TDI = 1'b0;
    logic           CAPTURE = 1'b0;
    logic           SHIFT = 1'b0;
    logic           UPDATE = 1'b0;
    logic           CLR_ERR = 1'b0;
    logic [N*W-1:0] PI = '0;
    logic [N*W-1:0] PO;
    logic [N-1:0]   UPD_STB;
    logic           LEN_ERR;
    logic           TDO;

    jtag_user_reg_bank #(
        .WIDTH(W), .NREG(N), .AW(A), .CAP_MASK(CMASK), .RST_VAL(8'h00)
    ) dut (
        .DRCK(DRCK), .RST(RST), .SEL(SEL), .ADDR(ADDR), .TDI(TDI),
        .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE), .CLR_ERR(CLR_ERR),
        .PI(PI), .PO(PO), .UPD_STB(UPD_STB), .LEN_ERR(LEN_ERR), .TDO(TDO)
    );

    always #5 DRCK = ~DRCK;

    // Reference model: channel contents as bytes, the scan path as a FIFO of bits.
    logic [W-1:0] po_m [N];
    logic         err_m;
    logic         srq [$];
    int           cnt_m;

    logic tdo_q [$];
    stb_t stb_q [$];
    st_t  st_q [$];
    logic chk_stat = 1'b0;

    int checks = 0;
    int errors = 0;

    function automatic logic [N*W-1:0] po_all();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = po_m[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) po_m[i] = 8'h00;
        err_m = 1'b0;
        cnt_m = 0;
        srq.delete();
        repeat (W) srq.push_back(1'b0);
    endtask

    task automatic drive(input logic cap, input logic sh, input logic upd, input logic tdi, input logic clr);
        logic [W-1:0] cv;
        logic [W-1:0] v;
        stb_t s;
        CAPTURE = cap; SHIFT = sh; UPDATE = upd; TDI = tdi; CLR_ERR = clr;
        if (sh) tdo_q.push_back((SEL && !RST) ? srq[0] : 1'b0);
        if (!RST) begin
            if (clr) err_m = 1'b0;
            if (SEL) begin
                if (cap) begin
                    cv = CMASK[ADDR] ? po_m[ADDR] : PI[ADDR*W +: W];
                    srq.delete();
                    for (int k = 0; k < W; k++) srq.push_back(cv[k]);
                    cnt_m = 0;
                end else if (sh) begin
                    void'(srq.pop_front());
                    srq.push_back(tdi);
                    cnt_m = (cnt_m >= W + 1) ? W + 1 : cnt_m + 1;
                end else if (upd) begin
                    if (cnt_m == W) begin
                        for (int k = 0; k < W; k++) v[k] = srq[k];
                        po_m[ADDR] = v;
                        s.stb = 4'b0001 << ADDR;
                        s.po  = po_all();
                        stb_q.push_back(s);
                    end else begin
                        err_m = 1'b1;
                    end
                    cnt_m = 0;
                end
            end
        end
        @(posedge DRCK);
        #1;
        CAPTURE = 0; SHIFT = 0; UPDATE = 0; TDI = 0; CLR_ERR = 0;
    endtask

    task automatic check_status();
        st_t t;
        t.po  = po_all();
        t.err = err_m;
        st_q.push_back(t);
        chk_stat = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk_stat = 1'b0;
    endtask

    task automatic scan(input int a, input logic [15:0] d, input int nsh, input logic [W-1:0] piv, input logic clr_upd);
        ADDR = a[A-1:0];
        PI[a*W +: W] = piv;
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < nsh; k++) drive(0, 1, 0, d[k], 0);
        drive(0, 0, 1, 0, clr_upd);
    endtask

    // Reset asserted asynchronously mid-cycle, held across one shift edge.
    task automatic reset_mid();
        #2;
        RST = 1'b1;
        model_reset();
        drive(0, 1, 0, 1, 0);
        RST = 1'b0;
    endtask

    always @(negedge DRCK) begin
        logic e;
        stb_t s;
        st_t  t;
        if (SHIFT) begin
            checks++;
            if (tdo_q.size() == 0) begin
                errors++;
                $display("FAIL tdo: unexpected shift sample, got %b", TDO);
            end else begin
                e = tdo_q.pop_front();
                if (TDO !== e) begin
                    errors++;
                    $display("FAIL tdo @%0t: got %b want %b", $time, TDO, e);
                end
            end
        end
        if (UPD_STB !== '0) begin
            checks++;
            if (stb_q.size() == 0) begin
                errors++;
                $display("FAIL upd_stb @%0t: unexpected strobe %b", $time, UPD_STB);
            end else begin
                s = stb_q.pop_front();
                if (UPD_STB !== s.stb || PO !== s.po) begin
                    errors++;
                    $display("FAIL upd_stb @%0t: got stb %b po %h want stb %b po %h", $time, UPD_STB, PO, s.stb, s.po);
                end
            end
        end
        if (chk_stat) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL status: no expectation queued");
            end else begin
                t = st_q.pop_front();
                if (PO !== t.po || LEN_ERR !== t.err) begin
                    errors++;
                    $display("FAIL status @%0t: got po %h len_err %b want po %h len_err %b", $time, PO, LEN_ERR, t.po, t.err);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        int a, nsh, r;
        model_reset();
        repeat (2) @(posedge DRCK);
        #1;
        SEL = 1'b1;
        drive(0, 1, 0, 1, 0);
        RST = 1'b0;
        check_status();

        scan(1, 16'hFFFF, 8, 8'hA5, 0);
        check_status();
        check_status();

        scan(0, 16'h00AA, 7, 8'h5A, 0);
        check_status();
        drive(0, 0, 0, 0, 1);
        check_status();
        scan(0, 16'h01F0, 9, 8'h33, 0);
        check_status();
        scan(0, 16'h0055, 7, 8'h11, 1);
        check_status();
        drive(0, 0, 0, 0, 1);
        check_status();

        scan(2, 16'h003C, 8, 8'h00, 0);
        scan(2, 16'h00FF, 8, 8'hFF, 0);
        check_status();

        SEL = 1'b0;
        ADDR = 2'd1;
        for (int k = 0; k < 8; k++) drive(0, 1, 0, 1'($urandom), 0);
        drive(0, 0, 1, 0, 0);
        SEL = 1'b1;
        check_status();
        for (int k = 0; k < 8; k++) drive(0, 1, 0, 1'($urandom), 0);
        drive(0, 0, 1, 0, 0);
        check_status();

        ADDR = 2'd3;
        PI[3*W +: W] = 8'h77;
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(0, 1, 0, 1, 0);
        reset_mid();
        check_status();
        drive(0, 0, 1, 0, 0);
        check_status();
        drive(0, 0, 0, 0, 1);

        repeat (80) begin
            a   = $urandom_range(0, N - 1);
            r   = $urandom_range(0, 5);
            nsh = (r < 3) ? 8 : (r == 3) ? 7 : (r == 4) ? 9 : $urandom_range(0, 12);
            SEL = ($urandom_range(0, 9) != 0);
            scan(a, 16'($urandom), nsh, 8'($urandom), ($urandom_range(0, 3) == 0));
            SEL = 1'b1;
            if ($urandom_range(0, 2) == 0) drive(0, 0, 0, 0, 1);
            check_status();
        end

        repeat (3) drive(0, 0, 0, 0, 0);
        checks++;
        if (tdo_q.size() != 0 || stb_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL drain: leftover tdo %0d stb %0d status %0d, want 0 0 0", tdo_q.size(), stb_q.size(), st_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
